// File: rtl/vga_rect_scheduler.sv
// vga_rect_scheduler: per-line rectangle selection from a double-buffered descriptor table (optional VGA_RECT_SCHED_STATS_EN adds overlap_count)
module vga_rect_scheduler #(
  parameter int NUM_RECT = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [9:0]       line_y,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [9:0]       wr_x0,
  input  logic [9:0]       wr_y0,
  input  logic [9:0]       wr_x1,
  input  logic [9:0]       wr_y1,
  input  logic [4:0]       wr_colour,
  input  logic             wr_enable,
  output logic [9:0]       rect_x0,
  output logic [9:0]       rect_y0,
  output logic [9:0]       rect_x1,
  output logic [9:0]       rect_y1,
  output logic [4:0]       rect_colour,
  output logic             rect_valid,
  output logic             overlap,
`ifdef VGA_RECT_SCHED_STATS_EN
  output logic [15:0]      overlap_count,
`endif
  output logic             scan_busy
);
  typedef enum logic [1:0] {IDLE, SCAN, LOAD} state_t;
  typedef struct packed {
    logic       en;
    logic [4:0] col;
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
  } desc_t;
  state_t state, state_d;
  desc_t sh [NUM_RECT];
  desc_t act [NUM_RECT];
  desc_t cap, cap_d, cur;
  logic [IDX_W-1:0] idx;
  logic [9:0] ly;
  logic found, found_d, hit, last, load_now, commit_pending;
  logic [1:0] cnt, cnt_d;
  assign scan_busy = state != IDLE;
  // next state and per-slot match evaluation
  always_comb begin
    cur = act[idx];
    last = idx == IDX_W'(NUM_RECT - 1);
    hit = state == SCAN && cur.en && ly >= cur.y0 && ly <= cur.y1;
    found_d = found | hit;
    cnt_d = hit ? ((cnt == 2'd2) ? cnt : cnt + 2'd1) : cnt;
    cap_d = (hit && !found) ? cur : cap;
    load_now = state == SCAN && last && !line_start;
    state_d = line_start ? SCAN : load_now ? LOAD : (state == LOAD) ? IDLE : state;
  end
  // shadow table writes and frame-start commit into the active table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        sh[i] <= '0;
        act[i] <= '0;
      end
      commit_pending <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      wr_ready <= !(frame_start && commit_pending);
      if (frame_start && commit_pending) begin
        act <= sh;
        commit_pending <= 1'b0;
      end
      if (wr_valid && wr_ready && {1'b0, wr_idx} < (IDX_W + 1)'(NUM_RECT)) begin
        sh[wr_idx] <= '{wr_enable, wr_colour, wr_x0, wr_y0, wr_x1, wr_y1};
        commit_pending <= 1'b1;
      end
    end
  end
  // scan state, first-match capture and renderer output load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      ly <= '0;
      found <= 1'b0;
      cnt <= '0;
      cap <= '0;
      {rect_x0, rect_y0, rect_x1, rect_y1} <= {10'd1023, 10'd1023, 10'd0, 10'd0};
      rect_colour <= '0;
      rect_valid <= 1'b0;
      overlap <= 1'b0;
    end else begin
      state <= state_d;
      if (line_start) begin
        ly <= line_y;
        idx <= '0;
        found <= 1'b0;
        cnt <= '0;
      end else if (state == SCAN) begin
        idx <= idx + 1'b1;
        found <= found_d;
        cnt <= cnt_d;
        cap <= cap_d;
      end
      if (load_now) begin
        {rect_x0, rect_y0, rect_x1, rect_y1} <= found_d ? {cap_d.x0, cap_d.y0, cap_d.x1, cap_d.y1}
                                                        : {10'd1023, 10'd1023, 10'd0, 10'd0};
        rect_colour <= found_d ? cap_d.col : 5'd0;
        rect_valid <= found_d;
        overlap <= cnt_d == 2'd2;
      end
    end
  end
`ifdef VGA_RECT_SCHED_STATS_EN
  // saturating count of overlapped lines, cleared every frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overlap_count <= '0;
    else if (frame_start) overlap_count <= '0;
    else if (load_now && cnt_d == 2'd2 && overlap_count != 16'hFFFF) overlap_count <= overlap_count + 16'd1;
  end
`endif
endmodule

// File: doc/vga_rect_scheduler.md
Name: vga_rect_scheduler

Overview:
- Holds a table of up to NUM_RECT rectangle-outline descriptors and shares one rectangle-outline renderer between them.
- During each horizontal blank it scans the table and selects the highest-priority (lowest index) enabled rectangle covering the next line. The selected geometry and colour drive the shared renderer for that whole line.
- Host writes go to a shadow table, which is committed atomically at frame start so nothing tears mid-frame.

Parameters:
- NUM_RECT, 8, number of descriptor slots.
- IDX_W, 3, slot index width; must satisfy 2^IDX_W >= NUM_RECT.

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- line_start  in  1  one-cycle pulse at start of horizontal blank
- line_y  in  10  line number that will be drawn after this blank; sampled on line_start
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high
- wr_idx  in  IDX_W  descriptor slot
- wr_x0, wr_y0, wr_x1, wr_y1  in  10 each  geometry, top-left (x0,y0) to bottom-right (x1,y1)
- wr_colour  in  5  colour code
- wr_enable  in  1  slot enable
- rect_x0, rect_y0, rect_x1, rect_y1  out  10 each  geometry to the shared renderer
- rect_colour  out  5  colour to the shared renderer
- rect_valid  out  1  a rectangle is selected for the current line
- overlap  out  1  more than one enabled rectangle matched the current line
- scan_busy  out  1  scan in progress

Behaviour:
- Reset (async, rst=1):
  - All shadow and active slots are disabled with zero geometry; commit_pending=0.
  - Outputs take null geometry: rect_x0=1023, rect_x1=0, rect_y0=1023, rect_y1=0. This guarantees no pixel satisfies the renderer's range checks.
  - rect_colour=0, rect_valid=0, overlap=0, scan_busy=0, wr_ready=1.
- Writes:
  - An accepted write updates shadow slot wr_idx and sets commit_pending=1.
  - wr_idx >= NUM_RECT: the write is accepted and discarded; no other effect.
  - wr_ready is a registered output. It is 0 only in the cycle immediately after frame_start while a commit executes; it is 1 otherwise.
- Commit:
  - On frame_start with commit_pending=1, the whole shadow table is copied to the active table in one cycle, then commit_pending clears.
  - A write accepted in the same cycle as frame_start lands in the shadow table and is committed at the next frame_start.
- Scan FSM, states IDLE, SCAN, LOAD:
  - IDLE -> SCAN on line_start: latch line_y; clear the found flag and match count; scan_busy=1.
  - SCAN: examines slot i = 0..NUM_RECT-1, one slot per clock. A slot matches when enable && line_y >= y0 && line_y <= y1, using 10-bit unsigned compares.
  - A slot with y0 > y1 never matches.
  - The first matching slot is captured; later matches only increment the match count, which saturates at 2.
  - After the last slot: SCAN -> LOAD.
  - LOAD: update all rect_* outputs, rect_valid and overlap in the same cycle. If nothing matched, output null geometry with rect_valid=0. Then -> IDLE and scan_busy=0.
  - Latency: outputs change NUM_RECT+1 cycles after the line_start cycle and hold until the next LOAD.
- Boundary conditions:
  - line_start during SCAN or LOAD: abort, re-latch line_y and restart at slot 0. Outputs keep their previous values.
  - frame_start and line_start in the same cycle: the commit happens that cycle and the scan reads the new active table.
  - frame_start during SCAN: the commit still happens, and the remaining slots are read from the new table. Software must not rely on mid-scan commits.
  - Geometry is passed through unmodified. x0 > x1 is legal and yields only side edges per renderer semantics.
  - Reset mid-scan returns to IDLE with reset outputs.

Optional Feature:
- Macro VGA_RECT_SCHED_STATS_EN.
- Defined: adds output overlap_count[15:0].
  - Increments in LOAD when overlap=1, saturating at 16'hFFFF.
  - Clears to 0 on reset and on frame_start.
- Undefined: port and counter absent; overlap still present.

Test Plan:
- Reset release -> rect_x0=1023, rect_x1=0, rect_y0=1023, rect_y1=0, rect_valid=0, wr_ready=1.
- Write slot 2 = (10,20)-(100,50), colour 5, enable=1; frame_start; line_start with line_y=20 -> after 9 cycles rect_valid=1, geometry (10,20,100,50), colour 5, overlap=0. Repeat with line_y=51 -> rect_valid=0, null geometry.
- Enable slot 1 (0,0)-(639,479) and slot 4 (5,5)-(9,9); line_y=7 -> slot 1 selected, overlap=1. With STATS_EN, overlap_count increments by 1 per such line.
- Write slot 3 without a following frame_start; scan line_y inside slot 3 -> not selected. After frame_start, rescan -> selected.
- line_start, then a second line_start 3 cycles later with a different line_y -> outputs unchanged until 9 cycles after the second pulse, and they reflect the second line_y.
- Slot with y0=300, y1=200, enable=1, line_y=250 -> no match. wr_idx=7 write with NUM_RECT=6 -> accepted, no table change.
